// File: rtl/fifo_port_sched_pkg.sv
// Shared sizing helpers for the FIFO port scheduler and its arbiter.
package fifo_sched_pkg;

  localparam int OBUF_DEPTH = 2;

  function automatic int aw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cw_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int iw_f(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fifo_port_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [iw_f(N)-1:0]  ptr,
  input  logic                en,
  output logic [N-1:0]        gnt,
  output logic [iw_f(N)-1:0]  idx
);

  localparam int IW = iw_f(N);
  localparam logic [IW:0] N_C = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  logic          found;

  // Scan the requests circularly starting from the priority pointer
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= N_C) begin
        sum = sum - N_C;
      end else begin
        sum = sum;
      end
      pos = sum[IW-1:0];
      if (en && !found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = pos;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_port_sched.sv
// Shares one single-port-RAM FIFO between NREQ producers and one consumer;
// credit-counted round-robin writes, 2-entry output buffer on the read side.
module fifo_port_sched
  import fifo_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_wr,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     fifo_rd,
  input  logic [WIDTH-1:0]         fifo_dout,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [iw_f(NREQ)-1:0]    grant_id,
  output logic [cw_f(DEPTH)-1:0]   occupancy
);

  localparam int IW = iw_f(NREQ);
  localparam int CW = cw_f(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_C  = IW'(NREQ - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             inflight_q;
  logic [WIDTH-1:0] buf_q [OBUF_DEPTH];
  logic             head_q, head_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;

  logic             grant_en;
  logic [IW-1:0]    win_idx;
  logic             push;
  logic             pop;
  logic [2:0]       pending;
  logic [1:0]       cnt_after_pop;
  logic             tail;

  assign grant_en = (cnt_q < DEPTH_C);

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (grant_en),
    .gnt (req_ready),
    .idx (win_idx)
  );

  assign push      = |req_ready;
  assign fifo_wr   = push;
  assign grant_id  = push ? win_idx : '0;
  assign occupancy = cnt_q;

  // Write-side data mux; drives zero when nobody is granted
  always_comb begin
    if (push) begin
      fifo_din = req_data[int'(win_idx)*WIDTH +: WIDTH];
    end else begin
      fifo_din = '0;
    end
  end

  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf_q[head_q];
  assign pop       = out_valid & out_ready;

  // A read is only issued if its data is guaranteed a buffer slot on arrival
  assign pending = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd = (cnt_q != '0) && (pending < 3'd2);

  // Next-state for credits, priority pointer and output-buffer bookkeeping
  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(fifo_rd);
    if (push) begin
      rr_ptr_d = (win_idx == LAST_C) ? '0 : win_idx + IW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    head_d        = head_q ^ pop;
    cnt_after_pop = buf_cnt_q - {1'b0, pop};
    tail          = head_d ^ cnt_after_pop[0];
    buf_cnt_d     = cnt_after_pop + {1'b0, inflight_q};
  end

  // State registers; returning read data lands behind whatever survives the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      buf_cnt_q  <= 2'd0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= fifo_rd;
      head_q     <= head_d;
      buf_cnt_q  <= buf_cnt_d;
      if (inflight_q) begin
        buf_q[tail] <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_port_sched.sv
// Randomized scoreboard bench for fifo_port_sched with a behavioural FIFO model.
module tb_fifo_port_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_wr;
  logic [WIDTH-1:0]       fifo_din;
  logic                   fifo_rd;
  logic [WIDTH-1:0]       fifo_dout;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [1:0]             grant_id;
  logic [3:0]             occupancy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int pop_cyc_q[$];

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  int ptr_m  = 0;
  bit infl_m = 1'b0;

  always #5 clk = ~clk;

  fifo_port_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant_id(grant_id), .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // FIFO with one-cycle read latency, sharing rst_n with the scheduler
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_rd && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (fifo_wr) fq.push_back(fifo_din);
    end
  end

  // Reference model and scoreboard monitor
  always @(negedge clk) begin
    int occ, bufd, w, j;
    bit popm, rdm;
    logic [NREQ-1:0] g;
    logic [WIDTH-1:0] d;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      ptr_m  = 0;
      infl_m = 1'b0;
    end else begin
      occ  = fq.size();
      check("occupancy", 32'(occupancy), 32'(occ));
      bufd = exp_q.size() - occ - int'(infl_m);
      check("buffer_bound", 32'(bufd >= 0 && bufd <= 2), 32'd1);
      check("out_valid", 32'(out_valid), 32'(bufd > 0));
      popm = (bufd > 0) && out_ready;
      if (bufd > 0 && exp_q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
      end
      if (popm && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
      end
      rdm = (occ != 0) && (bufd + int'(infl_m) - int'(popm) < 2);
      check("fifo_rd", 32'(fifo_rd), 32'(rdm));
      g = '0;
      w = 0;
      if (occ < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (ptr_m + k) % NREQ;
          if (req_valid[j] && g == '0) begin
            g[j] = 1'b1;
            w = j;
          end
        end
      end
      check("req_ready", 32'(req_ready), 32'(g));
      check("fifo_wr", 32'(fifo_wr), 32'(g != '0));
      check("grant_id", 32'(grant_id), (g != '0) ? 32'(w) : 32'd0);
      if (g != '0) begin
        d = req_data[w*WIDTH +: WIDTH];
        check("fifo_din", 32'(fifo_din), 32'(d));
        exp_q.push_back(d);
        ptr_m = (w + 1) % NREQ;
        push_cnt++;
      end
      infl_m = rdm;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_fifo_wr"},   32'(fifo_wr),   32'd0);
    check({tag, "_fifo_rd"},   32'(fifo_rd),   32'd0);
    check({tag, "_fifo_din"},  32'(fifo_din),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_grant_id"},  32'(grant_id),  32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  task automatic drain(input string tag);
    int i;
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check({tag, "_drained"}, 32'(exp_q.size() == 0 && !out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, idx, p0, base;
    rst_n = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("idle");

    // single push from producer 2, three-cycle latency to out_valid
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    @(negedge clk);
    check("lat_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("lat_cycles", 32'(k), 32'd3);
    check("lat_data", 32'(out_data), 32'hA5);
    drain("lat");

    // all producers valid, consumer stalled: fills to DEPTH plus buffer
    base = push_cnt;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      req_valid = 4'hF;
      req_data  = $urandom;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("full_occ", 32'(occupancy), 32'd8);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_pushes", 32'(push_cnt - base), 32'd10);

    // release the consumer while producers keep pushing
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      req_data = $urandom;
      @(posedge clk); #1;
    end
    drain("full");

    // streaming from producer 1 with data 0..31
    pop_cyc_q.delete();
    p0  = pop_cnt;
    idx = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && idx < 32; c++) begin
      @(posedge clk); #1;
      req_valid = 4'b0010;
      req_data  = 32'(idx) << 8;
      @(negedge clk);
      if (req_ready[1]) idx++;
    end
    check("stream_pushed", 32'(idx), 32'd32);
    drain("stream");
    check("stream_pops", 32'(pop_cnt - p0), 32'd32);
    if (pop_cyc_q.size() >= 32) begin
      check("stream_span", 32'(pop_cyc_q[31] - pop_cyc_q[0]), 32'd31);
    end else begin
      check("stream_span_count", 32'(pop_cyc_q.size()), 32'd32);
    end

    // random sparse producers and random consumer back-pressure
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(3) == 0);
      req_data  = $urandom;
      out_ready = 1'($urandom_range(1));
    end
    drain("random");

    // asynchronous reset with entries stored
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (k = 0; k < 50; k++) begin
      req_valid = 4'b1000;
      req_data  = $urandom;
      @(negedge clk);
      if (occupancy == 4'd5) break;
      @(posedge clk); #1;
    end
    check("pre_reset_occ", 32'(occupancy), 32'd5);
    #1;
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h3C);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
